// File: rtl/rom_arb_if.sv
// rom_arb_if: requester and ROM-side signal bundle for the shared boot-ROM arbiter
// Ports (slave = arbiter side):
//   req/lock/addr : per-requester read request, lock hint and word address
//   gnt/rvalid    : one-hot grant (combinational) and one-hot read-data valid (registered)
//   rdata         : read data returned from the ROM
//   rom_me/rom_adr/rom_q : single-port ROM enable, address and output data
//   busy          : access issued last cycle or ownership held
interface rom_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [NUM_REQ-1:0] req, lock, gnt, rvalid;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata, rom_q;
  logic [ADDR_W-1:0] rom_adr;
  logic rom_me, busy;
  modport slave (input req, lock, addr, rom_q, output gnt, rvalid, rdata, rom_me, rom_adr, busy);
  modport master (output req, lock, addr, rom_q, input gnt, rvalid, rdata, rom_me, rom_adr, busy);
endinterface

// File: rtl/rom_arb.sv
// rom_arb: round-robin arbiter sharing one single-port boot ROM, with bounded locked sequences
// Ports:
//   hclk   : clock, rising edge
//   hreset : synchronous active-high reset
//   bus    : rom_arb_if.slave (requests, grants, read return, ROM control)
module rom_arb #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int MAX_LOCK = 8
) (
  input logic hclk,
  input logic hreset,
  rom_arb_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
  localparam logic [CW-1:0] MAXC = CW'(MAX_LOCK);
  logic [PW-1:0] r_ptr, r_owner, w_base, w_win, w_ptr_nxt;
  logic [PW:0] w_j;
  logic [CW-1:0] r_cnt, w_n;
  logic [NUM_REQ-1:0] r_rvalid, w_own_oh, w_req, w_gnt;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_rdata;
  logic r_own_vld, r_busy, w_drop, w_hold, w_sat, w_keep, w_any;
  // wrap by compare so non-power-of-two requester counts stay in range
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] x);
    return (x == LAST) ? '0 : x + PW'(1);
  endfunction
  always_comb begin
    w_own_oh = r_own_vld ? NUM_REQ'(1) << r_owner : '0;
    w_drop = r_own_vld && !(|(bus.req & w_own_oh));
    w_hold = r_own_vld && !w_drop && r_cnt < MAXC;
    // a saturated owner steps aside as soon as anyone else is waiting
    w_sat = r_own_vld && r_cnt >= MAXC && |(bus.req & ~w_own_oh);
    w_req = hreset ? '0 : (w_sat ? bus.req & ~w_own_oh : bus.req);
    w_base = w_drop ? f_inc(r_owner) : r_ptr;
    w_win = w_base;
    w_j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = {1'b0, w_base} + (PW+1)'(k);
      w_j = (w_j >= NR) ? w_j - NR : w_j;
      w_win = w_req[w_j[PW-1:0]] ? w_j[PW-1:0] : w_win;
    end
    w_win = w_hold ? r_owner : w_win;
    w_any = |w_req;
    w_gnt = w_any ? NUM_REQ'(1) << w_win : '0;
    w_n = (r_own_vld && w_win == r_owner) ? ((r_cnt >= MAXC) ? MAXC : r_cnt + CW'(1)) : CW'(1);
    w_keep = w_any && bus.lock[w_win] && (w_n < MAXC || !(|(bus.req & ~w_gnt)));
    w_ptr_nxt = (w_any && !w_keep) ? f_inc(w_win) : w_base;
    w_adr = '0;
    for (int i = 0; i < NUM_REQ; i++) w_adr = w_gnt[i] ? bus.addr[i*ADDR_W +: ADDR_W] : w_adr;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_ptr <= '0;
      r_owner <= '0;
      r_own_vld <= 1'b0;
      r_cnt <= '0;
      r_rvalid <= '0;
      r_busy <= 1'b0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_owner <= w_win;
      r_own_vld <= w_keep;
      r_cnt <= w_keep ? w_n : '0;
      r_rvalid <= w_gnt;
      r_busy <= w_any | w_keep;
    end
  end
  assign w_rdata = bus.rom_q;
  assign bus.rdata = w_rdata;
  assign bus.gnt = w_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rom_me = w_any;
  assign bus.rom_adr = w_adr;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_rom_arb.sv
// tb_rom_arb: vector table, lock corner sequences and randomized run against a reference model
module tb_rom_arb;
  localparam int N = 3;
  localparam int MAXL = 8;
  logic hclk = 1'b0;
  logic hreset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] rom [512];
  rom_arb_if #(.NUM_REQ(N), .ADDR_W(9), .DATA_W(32)) bus ();
  rom_arb #(.NUM_REQ(N), .ADDR_W(9), .DATA_W(32), .MAX_LOCK(MAXL)) dut (.hclk(hclk), .hreset(hreset), .bus(bus));
  always #5 hclk = ~hclk;
  always @(posedge hclk) if (bus.rom_me) bus.rom_q <= rom[bus.rom_adr];
  // reference model: integer owner/pointer bookkeeping derived from the arbitration rules
  int m_ptr = 0, m_owner = -1, m_cnt = 0;
  logic [2:0] m_rv = '0;
  logic m_busy = 1'b0;
  logic [8:0] m_radr = '0;
  function automatic logic [8:0] slice_adr(input int w);
    return (w >= 0) ? bus.addr[w*9 +: 9] : 9'h0;
  endfunction
  function automatic void m_eval(output int win, output int np, output int no, output int nc);
    int p, o, c, n;
    bit oth, otw;
    p = m_ptr; o = m_owner; c = m_cnt; win = -1;
    if (o >= 0 && !bus.req[o]) begin p = (o + 1) % N; o = -1; c = 0; end
    oth = 0;
    for (int i = 0; i < N; i++) if (i != o && bus.req[i]) oth = 1;
    if (!hreset) begin
      if (o >= 0 && c < MAXL) win = o;
      else for (int k = 0; k < N; k++) begin
        int i;
        i = (p + k) % N;
        if (win < 0 && bus.req[i] && !(i == o && oth)) win = i;
      end
    end
    np = p; no = o; nc = c;
    if (win >= 0) begin
      n = (win == o) ? ((c + 1 > MAXL) ? MAXL : c + 1) : 1;
      otw = 0;
      for (int i = 0; i < N; i++) if (i != win && bus.req[i]) otw = 1;
      if (bus.lock[win] && (n < MAXL || !otw)) begin no = win; nc = n; end
      else begin no = -1; nc = 0; np = (win + 1) % N; end
    end
  endfunction
  always @(posedge hclk) begin
    int w, np, no, nc;
    m_eval(w, np, no, nc);
    if (hreset) begin
      m_ptr <= 0; m_owner <= -1; m_cnt <= 0; m_rv <= '0; m_busy <= 1'b0;
    end else begin
      m_ptr <= np; m_owner <= no; m_cnt <= nc;
      m_rv <= (w >= 0) ? 3'(1 << w) : 3'b0;
      m_busy <= (w >= 0);
      m_radr <= slice_adr(w);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic [2:0] rq, input logic [2:0] lk);
    hreset = r; bus.req = rq; bus.lock = lk;
    @(negedge hclk);
  endtask
  task automatic tick();
    @(posedge hclk); #1;
  endtask
  task automatic do_reset();
    drive(1'b1, 3'b000, 3'b000); tick();
    hreset = 1'b0;
  endtask
  typedef struct {
    logic rst; logic [2:0] req; logic [2:0] gnt; logic [8:0] adr; logic [2:0] rv; logic busy; logic [8:0] rdadr;
  } vec_t;
  vec_t tbl[16];
  initial begin
    for (int i = 0; i < 512; i++) rom[i] = $urandom;
    bus.req = '0; bus.lock = '0; bus.addr = {9'h1F0, 9'h011, 9'h005};
    tbl[0]  = '{1'b1, 3'b111, 3'b000, 9'h000, 3'b000, 1'b0, 9'h000};
    tbl[1]  = '{1'b0, 3'b111, 3'b001, 9'h005, 3'b000, 1'b0, 9'h000};
    tbl[2]  = '{1'b0, 3'b111, 3'b010, 9'h011, 3'b001, 1'b1, 9'h005};
    tbl[3]  = '{1'b0, 3'b111, 3'b100, 9'h1F0, 3'b010, 1'b1, 9'h011};
    tbl[4]  = '{1'b0, 3'b111, 3'b001, 9'h005, 3'b100, 1'b1, 9'h1F0};
    tbl[5]  = '{1'b0, 3'b111, 3'b010, 9'h011, 3'b001, 1'b1, 9'h005};
    tbl[6]  = '{1'b0, 3'b111, 3'b100, 9'h1F0, 3'b010, 1'b1, 9'h011};
    tbl[7]  = '{1'b0, 3'b000, 3'b000, 9'h000, 3'b100, 1'b1, 9'h1F0};
    tbl[8]  = '{1'b0, 3'b000, 3'b000, 9'h000, 3'b000, 1'b0, 9'h000};
    tbl[9]  = '{1'b0, 3'b001, 3'b001, 9'h005, 3'b000, 1'b0, 9'h000};
    tbl[10] = '{1'b0, 3'b000, 3'b000, 9'h000, 3'b001, 1'b1, 9'h005};
    tbl[11] = '{1'b0, 3'b010, 3'b010, 9'h011, 3'b000, 1'b0, 9'h000};
    tbl[12] = '{1'b1, 3'b000, 3'b000, 9'h000, 3'b010, 1'b1, 9'h011};
    tbl[13] = '{1'b0, 3'b110, 3'b010, 9'h011, 3'b000, 1'b0, 9'h000};
    tbl[14] = '{1'b0, 3'b100, 3'b100, 9'h1F0, 3'b010, 1'b1, 9'h011};
    tbl[15] = '{1'b0, 3'b000, 3'b000, 9'h000, 3'b100, 1'b1, 9'h1F0};
    repeat (3) @(posedge hclk);
    #1;
    for (int v = 0; v < 16; v++) begin
      drive(tbl[v].rst, tbl[v].req, 3'b000);
      chk($sformatf("tbl%0d_gnt", v), 32'(bus.gnt), 32'(tbl[v].gnt));
      chk($sformatf("tbl%0d_rom_me", v), 32'(bus.rom_me), 32'(|tbl[v].gnt));
      chk($sformatf("tbl%0d_adr", v), 32'(bus.rom_adr), 32'(tbl[v].adr));
      chk($sformatf("tbl%0d_rvalid", v), 32'(bus.rvalid), 32'(tbl[v].rv));
      chk($sformatf("tbl%0d_busy", v), 32'(bus.busy), 32'(tbl[v].busy));
      if (tbl[v].rv != 3'b000) chk($sformatf("tbl%0d_rdata", v), bus.rdata, rom[tbl[v].rdadr]);
      tick();
    end
    // locked owner with contention: eight grants, then round robin resumes
    do_reset();
    drive(1'b0, 3'b001, 3'b000); chk("lockA_pre", 32'(bus.gnt), 32'h1); tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 3'b111, 3'b010);
      chk($sformatf("lockA_gnt%0d", k), 32'(bus.gnt), (k < 8) ? 32'h2 : (k == 8) ? 32'h4 : 32'h1);
      tick();
    end
    // locked owner alone saturates, then yields immediately
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 3'b100, 3'b100); chk($sformatf("lockB_gnt%0d", k), 32'(bus.gnt), 32'h4); tick();
    end
    drive(1'b0, 3'b101, 3'b100); chk("lockB_yield", 32'(bus.gnt), 32'h1); tick();
    // unsaturated owner finishes its remaining budget before yielding
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'b100, 3'b100); chk($sformatf("lockC_pre%0d", k), 32'(bus.gnt), 32'h4); tick();
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 3'b101, 3'b100); chk($sformatf("lockC_gnt%0d", k), 32'(bus.gnt), (k < 5) ? 32'h4 : 32'h1); tick();
    end
    // owner drops its request while holding the lock
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'b001, 3'b001); chk($sformatf("drop_pre%0d", k), 32'(bus.gnt), 32'h1); tick();
    end
    drive(1'b0, 3'b010, 3'b000); chk("drop_gnt", 32'(bus.gnt), 32'h2); tick();
    drive(1'b0, 3'b011, 3'b000); chk("drop_next", 32'(bus.gnt), 32'h1); tick();
    // randomized traffic with the request-hold handshake, compared to the model
    do_reset();
    begin
      logic [2:0] g_prev;
      int w, np, no, nc;
      g_prev = '0;
      for (int c = 0; c < 800; c++) begin
        for (int i = 0; i < N; i++) if (g_prev[i] || !bus.req[i]) begin
          bus.req[i] = ($urandom_range(0, 99) < 70);
          bus.lock[i] = ($urandom_range(0, 99) < 50);
          bus.addr[i*9 +: 9] = 9'($urandom_range(0, 511));
        end
        drive(($urandom_range(0, 99) < 2), bus.req, bus.lock);
        m_eval(w, np, no, nc);
        chk("rnd_gnt", 32'(bus.gnt), (w >= 0) ? 32'(1 << w) : 32'h0);
        chk("rnd_rom_me", 32'(bus.rom_me), 32'(w >= 0));
        chk("rnd_adr", 32'(bus.rom_adr), 32'(slice_adr(w)));
        chk("rnd_rvalid", 32'(bus.rvalid), 32'(m_rv));
        chk("rnd_busy", 32'(bus.busy), 32'(m_busy));
        if (m_rv != 3'b000) chk("rnd_rdata", bus.rdata, rom[m_radr]);
        g_prev = bus.gnt;
        tick();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
